// File: rtl/video_sync_rx.sv
// Recovers active-area coordinates from incoming hsync/vsync/de timing and
// locks once several consecutive frames measure identically.
module video_sync_rx #(
  parameter int CORDW       = 10,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 2**20
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de_out,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic [CORDW-1:0] h_total,
  output logic [CORDW-1:0] h_active,
  output logic [CORDW-1:0] v_total,
  output logic [CORDW-1:0] v_active
);

  localparam logic [CORDW-1:0] CMAX = '1;
  localparam logic [CORDW-1:0] ONE  = CORDW'(1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  logic hs_in, vs_in;
  logic hs_s, vs_s, de_s, hs_p, vs_p, de_p, armed;
  logic ls_w, fs_w, hse_w;

  assign hs_in = (hsync == SYNC_POL);
  assign vs_in = (vsync == SYNC_POL);

  // First post-reset sample seeds both stages so no edge appears against the forced-inactive reset value.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      {hs_s, vs_s, de_s, hs_p, vs_p, de_p, armed} <= '0;
    end else begin
      {hs_s, vs_s, de_s} <= {hs_in, vs_in, de};
      armed <= 1'b1;
      if (armed) {hs_p, vs_p, de_p} <= {hs_s, vs_s, de_s};
      else       {hs_p, vs_p, de_p} <= {hs_in, vs_in, de};
    end
  end

  assign ls_w  = de_s & ~de_p;
  assign fs_w  = vs_s & ~vs_p;
  assign hse_w = hs_s & ~hs_p;

  logic sy_first;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      de_out      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sy_first    <= 1'b0;
    end else begin
      de_out      <= de_s;
      line_start  <= ls_w;
      frame_start <= fs_w;
      if (ls_w)      sx <= '0;
      else if (de_s) sx <= sat_inc(sx);
      if (ls_w) begin
        if (sy_first || fs_w) begin
          sy       <= '0;
          sy_first <= 1'b0;
        end else begin
          sy <= sat_inc(sy);
        end
      end else if (fs_w) begin
        sy_first <= 1'b1;
      end
    end
  end

  logic [CORDW-1:0] h_cnt, ht_last, ha_cnt, vl_cnt, vt_cnt;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      {h_cnt, ht_last, ha_cnt, vl_cnt, vt_cnt} <= '0;
    end else begin
      if (ls_w) begin
        ht_last <= h_cnt;
        h_cnt   <= ONE;
        ha_cnt  <= ONE;
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (de_s) ha_cnt <= sat_inc(ha_cnt);
      end
      if (fs_w) begin
        vl_cnt <= ls_w  ? ONE : '0;
        vt_cnt <= hse_w ? ONE : '0;
      end else begin
        if (ls_w)  vl_cnt <= sat_inc(vl_cnt);
        if (hse_w) vt_cnt <= sat_inc(vt_cnt);
      end
    end
  end

  state_t           state;
  logic [TW-1:0]    to_cnt;
  logic [MW-1:0]    match_cnt;
  logic             have_ref, meas_match;
  logic [CORDW-1:0] ref_ht, ref_ha, ref_vt, ref_va;

  always_comb begin
    meas_match = (ht_last == ref_ht) && (ha_cnt == ref_ha) &&
                 (vt_cnt == ref_vt) && (vl_cnt == ref_va) && (vl_cnt != '0);
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state     <= SEARCH;
      to_cnt    <= '0;
      match_cnt <= '0;
      have_ref  <= 1'b0;
      locked    <= 1'b0;
      {ref_ht, ref_ha, ref_vt, ref_va}         <= '0;
      {h_total, h_active, v_total, v_active}   <= '0;
    end else if (fs_w) begin
      to_cnt <= '0;
      case (state)
        SEARCH: begin
          state     <= MEASURE;
          have_ref  <= 1'b0;
          match_cnt <= '0;
        end
        MEASURE: begin
          if (!have_ref || !meas_match) begin
            {ref_ht, ref_ha, ref_vt, ref_va} <= {ht_last, ha_cnt, vt_cnt, vl_cnt};
            have_ref  <= 1'b1;
            match_cnt <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt == LOCK_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
              {h_total, h_active, v_total, v_active} <= {ref_ht, ref_ha, ref_vt, ref_va};
            end
          end
        end
        LOCKED: begin
          if (!meas_match) begin
            state     <= MEASURE;
            locked    <= 1'b0;
            match_cnt <= '0;
            have_ref  <= 1'b1;
            {ref_ht, ref_ha, ref_vt, ref_va} <= {ht_last, ha_cnt, vt_cnt, vl_cnt};
          end
        end
        default: state <= SEARCH;
      endcase
    end else if (to_cnt == TO_LAST) begin
      to_cnt <= '0;
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_video_sync_rx.sv
// Scoreboard bench for video_sync_rx using a reduced raster with the same
// porch/sync structure as 640x480 (80x17 total, 64x12 active, active-low sync).
module tb_video_sync_rx;

  localparam int CORDW   = 10;
  localparam int TIMEOUT = 3000;
  localparam int H_ACT = 64, HFP = 2, HSW = 8, H_TOT = 80;
  localparam int V_ACT = 12, VFP = 1, VSW = 2, V_TOT = 17;
  localparam int E_HT = 80, E_HA = 64, E_VT = 17, E_VA = 12;

  logic             clk_pix = 1'b0;
  logic             rst = 1'b1;
  logic             hsync = 1'b1, vsync = 1'b1, de = 1'b0;
  logic [CORDW-1:0] sx, sy, h_total, h_active, v_total, v_active;
  logic             de_out, line_start, frame_start, locked;

  video_sync_rx #(
    .CORDW(CORDW), .SYNC_POL(1'b0), .LOCK_FRAMES(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_pix(clk_pix), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
    .sx(sx), .sy(sy), .de_out(de_out), .line_start(line_start),
    .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {logic lk; int ht; int ha; int vt; int va;} fs_exp_t;
  typedef struct {int sx; int sy;} pos_exp_t;

  fs_exp_t  fs_q[$];
  int       ls_q[$];
  pos_exp_t eol_q[$];
  int checks = 0;
  int errors = 0;
  int sy_ok  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual event with no expectation queued, required none", name);
  endtask

  // Monitor: pops expectations whenever the DUT emits an event.
  logic     prev_de = 1'b0;
  int       prev_sx, prev_sy;
  fs_exp_t  fe;
  int       le;
  pos_exp_t pe;

  always @(negedge clk_pix) begin
    if (rst) begin
      prev_de = 1'b0;
    end else begin
      if (frame_start) begin
        if (fs_q.size() == 0) unexpected("frame_start");
        else begin
          fe = fs_q.pop_front();
          check("fs_locked",   locked,   fe.lk);
          check("fs_h_total",  h_total,  fe.ht);
          check("fs_h_active", h_active, fe.ha);
          check("fs_v_total",  v_total,  fe.vt);
          check("fs_v_active", v_active, fe.va);
        end
      end
      if (line_start) begin
        if (ls_q.size() == 0) unexpected("line_start");
        else begin
          le = ls_q.pop_front();
          check("ls_sx", sx, 0);
          check("ls_de_out", de_out, 1);
          if (le >= 0) check("ls_sy", sy, le);
        end
      end
      if (prev_de && !de_out) begin
        if (eol_q.size() == 0) unexpected("line_end");
        else begin
          pe = eol_q.pop_front();
          if (pe.sx >= 0) check("eol_sx", prev_sx, pe.sx);
          if (pe.sy >= 0) check("eol_sy", prev_sy, pe.sy);
        end
      end
      prev_de = de_out;
      prev_sx = int'(sx);
      prev_sy = int'(sy);
    end
  end

  task automatic drive(input logic h, input logic v, input logic d);
    hsync = h; vsync = v; de = d;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic frame(input int htot, input bit vs_en, input logic lk,
                       input int ht, input int ha, input int vt, input int va,
                       input int rst_line);
    bit line_rst;
    if (!vs_en) sy_ok = 0;
    for (int l = 0; l < V_TOT; l++) begin
      line_rst = 1'b0;
      for (int h = 0; h < htot; h++) begin
        logic dv, hv, vv;
        dv = (l < V_ACT) && (h < H_ACT);
        hv = !((h >= H_ACT + HFP) && (h < H_ACT + HFP + HSW));
        vv = !(vs_en && (l >= V_ACT + VFP) && (l < V_ACT + VFP + VSW));
        if (vs_en && l == V_ACT + VFP && h == 0) begin
          fs_q.push_back('{lk, ht, ha, vt, va});
          sy_ok = 1;
        end
        if (dv && h == 0) ls_q.push_back(sy_ok != 0 ? l : -1);
        if (l < V_ACT && h == H_ACT)
          eol_q.push_back('{line_rst ? -1 : H_ACT - 1, sy_ok != 0 ? l : -1});
        if (l == rst_line && h == 32) begin
          check("sx_before_rst", sx, 30);
          rst = 1'b1;
          drive(hv, vv, dv);
          check("rst_sx", sx, 0);
          check("rst_sy", sy, 0);
          check("rst_de_out", de_out, 0);
          check("rst_line_start", line_start, 0);
          check("rst_frame_start", frame_start, 0);
          check("rst_locked", locked, 0);
          check("rst_h_total", h_total, 0);
          check("rst_h_active", h_active, 0);
          check("rst_v_total", v_total, 0);
          check("rst_v_active", v_active, 0);
          rst = 1'b0;
          line_rst = 1'b1;
          sy_ok = 0;
        end else begin
          drive(hv, vv, dv);
        end
      end
    end
  endtask

  initial begin
    repeat (4) drive(1'b1, 1'b1, 1'b0);
    check("init_locked", locked, 0);
    check("init_sx", sx, 0);
    check("init_h_total", h_total, 0);
    rst = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b0);

    // Acquire: locked with the 4th frame start.
    repeat (3) frame(H_TOT, 1, 1'b0, 0, 0, 0, 0, -1);
    repeat (3) frame(H_TOT, 1, 1'b1, E_HT, E_HA, E_VT, E_VA, -1);

    // One 81-clock-line frame, then three matching frames to re-lock.
    frame(H_TOT + 1, 1, 1'b0, E_HT, E_HA, E_VT, E_VA, -1);
    repeat (2) frame(H_TOT, 1, 1'b0, E_HT, E_HA, E_VT, E_VA, -1);
    repeat (2) frame(H_TOT, 1, 1'b1, E_HT, E_HA, E_VT, E_VA, -1);

    // vsync withheld past the timeout, then a full re-acquire from SEARCH.
    frame(H_TOT, 0, 1'b0, 0, 0, 0, 0, -1);
    check("locked_before_timeout", locked, 1);
    repeat (2) frame(H_TOT, 0, 1'b0, 0, 0, 0, 0, -1);
    check("locked_after_timeout", locked, 0);
    repeat (3) frame(H_TOT, 1, 1'b0, E_HT, E_HA, E_VT, E_VA, -1);
    frame(H_TOT, 1, 1'b1, E_HT, E_HA, E_VT, E_VA, -1);

    // Reset mid-line, then re-acquire from cleared state.
    frame(H_TOT, 1, 1'b0, 0, 0, 0, 0, 2);
    repeat (2) frame(H_TOT, 1, 1'b0, 0, 0, 0, 0, -1);
    frame(H_TOT, 1, 1'b1, E_HT, E_HA, E_VT, E_VA, -1);

    // Over-long active run: sx must pin at 1023.
    ls_q.push_back(0);
    eol_q.push_back('{1023, 0});
    repeat (1100) drive(1'b1, 1'b1, 1'b1);
    repeat (10) drive(1'b1, 1'b1, 1'b0);

    check("fs_queue_drained", fs_q.size(), 0);
    check("ls_queue_drained", ls_q.size(), 0);
    check("eol_queue_drained", eol_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
